// File: rtl/epd_stream_arbiter_pkg.sv
// Shared types and defaults for the epd stream arbiter.
// Holds FSM encoding, default parameters and a width helper.
package epd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_IDLE_GAP  = 2;
  localparam int DEF_TIMEOUT   = 1600;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/epd_stream_arbiter_if.sv
// Source/detector bundle for the epd stream arbiter.
// slave: arbiter view; master: sources + detector view.
interface epd_stream_arbiter_if
  import epd_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
);
  localparam int PW = clog2w(NUM_PORTS);

  logic [NUM_PORTS-1:0]   req;
  logic [8*NUM_PORTS-1:0] data_in;
  logic [NUM_PORTS-1:0]   control_in;
  logic [NUM_PORTS-1:0]   grant;
  logic [PW-1:0]          active_port;
  logic                   busy;
  logic [7:0]             epd_data;
  logic                   epd_control;
  logic                   epd_packet_size_valid;
  logic [NUM_PORTS-1:0]   done;
  logic                   pkt_ok;
  logic                   timeout_err;

  modport slave (
    input  req, data_in, control_in,
    input  epd_packet_size_valid,
    output grant, active_port, busy,
    output epd_data, epd_control,
    output done, pkt_ok, timeout_err
  );

  modport master (
    output req, data_in, control_in,
    output epd_packet_size_valid,
    input  grant, active_port, busy,
    input  epd_data, epd_control,
    input  done, pkt_ok, timeout_err
  );

endinterface

// File: rtl/epd_stream_arbiter_rr_select.sv
// Round-robin picker: first set req above i_ptr, wrapping.
// Ports: i_req, i_ptr -> o_found, o_sel. Combinational.
module epd_rr_select
  import epd_arb_pkg::*;
#(
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  localparam int PW = clog2w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PW-1:0]        i_ptr,
  output logic                 o_found,
  output logic [PW-1:0]        o_sel
);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_found = 1'b0;
    o_sel   = '0;
    w_idx   = i_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_idx == PW'(NUM_PORTS - 1))
        w_idx = '0;
      else
        w_idx = w_idx + 1'b1;
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_sel   = w_idx;
      end
    end
  end

endmodule

// File: rtl/epd_stream_arbiter.sv
// Packet-granular RR share of one detector over NUM_PORTS.
// Ports: clock, reset (async low), bus (slave modport).
module epd_stream_arbiter
  import epd_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDLE_GAP  = DEF_IDLE_GAP,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic clock,
  input logic reset,
  epd_stream_arbiter_if.slave bus
);

  localparam int PW = clog2w(NUM_PORTS);
  localparam int CW = clog2w(TIMEOUT + 1);
  localparam int GW = clog2w(IDLE_GAP + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
  localparam logic [GW-1:0] G_LAST = GW'(IDLE_GAP - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant;
  logic [NUM_PORTS-1:0] r_done;
  logic [PW-1:0]        r_active;
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_cnt;
  logic [GW-1:0]        r_gap;
  logic                 r_size;
  logic                 r_pkt_ok;
  logic                 r_tmo;

  logic [PW-1:0] w_sel;
  logic          w_found;
  logic          w_start;
  logic          w_rel_ok;
  logic          w_rel_tmo;
  logic          w_gap_end;
  logic          w_req_act;
  logic          w_ctrl_act;
  logic [7:0]    w_byte_act;
  logic [7:0]    w_bytes [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_bytes
    assign w_bytes[i] = bus.data_in[8*i +: 8];
  end

  assign w_byte_act = w_bytes[r_active];
  assign w_ctrl_act = bus.control_in[r_active];
  assign w_req_act  = bus.req[r_active];

  epd_rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_sel (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_sel   (w_sel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // A dropped req wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rel_ok    = 1'b0;
    w_rel_tmo   = 1'b0;
    w_gap_end   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_req_act) begin
          w_rel_ok    = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == C_LAST) begin
          w_rel_tmo   = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == G_LAST) begin
          w_gap_end   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant  <= '0;
      r_active <= '0;
      r_ptr    <= PW'(NUM_PORTS - 1);
      r_cnt    <= '0;
      r_gap    <= '0;
      r_size   <= 1'b0;
      r_done   <= '0;
      r_pkt_ok <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_done   <= '0;
      r_pkt_ok <= 1'b0;
      r_tmo    <= 1'b0;
      if (w_start) begin
        r_grant  <= NUM_PORTS'(1) << w_sel;
        r_active <= w_sel;
        r_ptr    <= w_sel;
        r_cnt    <= '0;
        r_size   <= 1'b0;
      end
      if (r_state == ST_GRANT) begin
        if (r_cnt != C_MAX)
          r_cnt <= r_cnt + 1'b1;
        r_size <= r_size | bus.epd_packet_size_valid;
      end
      if (w_rel_ok) begin
        r_grant  <= '0;
        r_done   <= NUM_PORTS'(1) << r_active;
        r_pkt_ok <= r_size | bus.epd_packet_size_valid;
      end
      if (w_rel_tmo) begin
        r_grant <= '0;
        r_tmo   <= 1'b1;
      end
      if (w_gap_end)
        r_gap <= '0;
      else if (r_state == ST_GAP)
        r_gap <= r_gap + 1'b1;
    end
  end

  // Detector path is muxed off state so reset blanks it at once.
  assign bus.epd_data    = (r_state == ST_GRANT) ? w_byte_act : 8'h00;
  assign bus.epd_control = (r_state == ST_GRANT) ? w_ctrl_act : 1'b0;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.grant       = r_grant;
  assign bus.active_port = r_active;
  assign bus.done        = r_done;
  assign bus.pkt_ok      = r_pkt_ok;
  assign bus.timeout_err = r_tmo;

endmodule

// File: tb/tb_epd_stream_arbiter.sv
// Directed bench for epd_stream_arbiter.
// Checks reset, RR order, gaps, timeout and data muxing.
module tb_epd_stream_arbiter;
  import epd_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  epd_stream_arbiter_if #(.NUM_PORTS(4)) bus();

  epd_stream_arbiter #(
    .NUM_PORTS (4),
    .IDLE_GAP  (2),
    .TIMEOUT   (1600)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int w);
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (bus.grant == '0 && w < 50);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    logic [7:0] v;
    bus.req = '0;
    bus.data_in = '0;
    bus.control_in = '0;
    bus.epd_packet_size_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_active", 32'(bus.active_port), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pkt_ok", 32'(bus.pkt_ok), 0);
    chk("rst_tmo", 32'(bus.timeout_err), 0);
    chk("rst_data", 32'(bus.epd_data), 0);
    reset = 1'b1;
    @(negedge clock);

    // single port 1, 72 cycles, one size-valid pulse
    bus.data_in = 32'h4433_A511;
    bus.control_in = 4'b0010;
    bus.req = 4'b0010;
    @(negedge clock);
    chk("a_grant", 32'(bus.grant), 'h2);
    chk("a_active", 32'(bus.active_port), 1);
    chk("a_busy", 32'(bus.busy), 1);
    chk("a_data", 32'(bus.epd_data), 'hA5);
    chk("a_ctrl", 32'(bus.epd_control), 1);
    for (int i = 2; i <= 72; i++) begin
      bus.epd_packet_size_valid = (i == 30);
      v = 8'(i);
      bus.data_in[15:8] = v;
      #1;
      if (i == 40) chk("a_track", 32'(bus.epd_data), 32'(v));
      @(negedge clock);
    end
    bus.req = '0;
    bus.epd_packet_size_valid = 1'b0;
    @(negedge clock);
    chk("a_rel_grant", 32'(bus.grant), 0);
    chk("a_done", 32'(bus.done), 'h2);
    chk("a_pkt_ok", 32'(bus.pkt_ok), 1);
    chk("a_tmo", 32'(bus.timeout_err), 0);
    chk("a_gap1_data", 32'(bus.epd_data), 0);
    chk("a_gap1_busy", 32'(bus.busy), 1);
    @(negedge clock);
    chk("a_done_clr", 32'(bus.done), 0);
    chk("a_gap2_data", 32'(bus.epd_data), 0);
    chk("a_gap2_busy", 32'(bus.busy), 1);
    @(negedge clock);
    chk("a_idle_busy", 32'(bus.busy), 0);

    // reset while port 2 holds the grant
    bus.data_in = 32'h553C_6677;
    bus.control_in = 4'b0100;
    bus.req = 4'b0100;
    @(negedge clock);
    chk("r_grant", 32'(bus.grant), 'h4);
    chk("r_data", 32'(bus.epd_data), 'h3C);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("r_async_grant", 32'(bus.grant), 0);
    chk("r_async_data", 32'(bus.epd_data), 0);
    chk("r_async_ctrl", 32'(bus.epd_control), 0);
    chk("r_async_busy", 32'(bus.busy), 0);
    @(negedge clock);
    chk("r_no_done", 32'(bus.done), 0);
    chk("r_no_tmo", 32'(bus.timeout_err), 0);

    // ports 0 and 2, no size-valid; port 0 first after reset
    bus.req = 4'b0101;
    bus.control_in = 4'b0001;
    reset = 1'b1;
    @(negedge clock);
    chk("m_first_p0", 32'(bus.grant), 'h1);
    for (int i = 0; i < 6; i++) begin
      v = 8'(i * 37 + 5);
      bus.data_in[7:0] = v;
      bus.data_in[23:16] = ~v;
      #1;
      chk("m_track_p0", 32'(bus.epd_data), 32'(v));
      @(negedge clock);
    end
    chk("m_ctrl_p0", 32'(bus.epd_control), 1);
    bus.req = 4'b0100;
    @(negedge clock);
    chk("m_done_p0", 32'(bus.done), 'h1);
    chk("m_pkt_ok_p0", 32'(bus.pkt_ok), 0);
    wait_grant(w);
    chk("m_grant_p2", 32'(bus.grant), 'h4);
    for (int i = 0; i < 6; i++) begin
      v = 8'(i * 53 + 9);
      bus.data_in[23:16] = v;
      bus.data_in[7:0] = ~v;
      #1;
      chk("m_track_p2", 32'(bus.epd_data), 32'(v));
      @(negedge clock);
    end
    chk("m_ctrl_p2", 32'(bus.epd_control), 0);
    bus.req = '0;
    @(negedge clock);
    chk("m_done_p2", 32'(bus.done), 'h4);
    chk("m_pkt_ok_p2", 32'(bus.pkt_ok), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // all four requesting: order 0,1,2,3,0 with 3-cycle spacing
    bus.req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      int p;
      p = g % 4;
      wait_grant(w);
      chk("rr_grant", 32'(bus.grant), 32'(1 << p));
      if (g > 0) chk("rr_spacing", 32'(w), 3);
      repeat (19) @(negedge clock);
      bus.req = bus.req & ~4'(1 << p);
      @(negedge clock);
      if (g < 4) bus.req = bus.req | 4'(1 << p);
      else bus.req = '0;
    end
    repeat (4) @(negedge clock);

    // port 3 runs into the timeout; port 1 joins meanwhile
    bus.req = 4'b1000;
    @(negedge clock);
    chk("to_grant", 32'(bus.grant), 'h8);
    n = 0;
    while (bus.grant == 4'b1000 && n < 2100) begin
      n++;
      if (n == 100) bus.req = 4'b1010;
      @(negedge clock);
    end
    chk("to_len", 32'(n), 1600);
    chk("to_err", 32'(bus.timeout_err), 1);
    chk("to_no_done", 32'(bus.done), 0);
    chk("to_grant_low", 32'(bus.grant), 0);
    @(negedge clock);
    chk("to_err_clr", 32'(bus.timeout_err), 0);
    wait_grant(w);
    chk("to_next_p1", 32'(bus.grant), 'h2);
    repeat (4) @(negedge clock);
    bus.req = 4'b1000;
    @(negedge clock);
    chk("to_done_p1", 32'(bus.done), 'h2);
    wait_grant(w);
    chk("to_regrant_p3", 32'(bus.grant), 'h8);
    repeat (4) @(negedge clock);
    bus.req = '0;
    @(negedge clock);
    chk("to_done_p3", 32'(bus.done), 'h8);
    chk("to_no_err_p3", 32'(bus.timeout_err), 0);
    repeat (3) @(negedge clock);

    // req drops exactly on the last allowed cycle
    bus.req = 4'b0001;
    @(negedge clock);
    chk("co_grant", 32'(bus.grant), 'h1);
    n = 1;
    while (n < 1600) begin
      @(negedge clock);
      n++;
    end
    chk("co_still", 32'(bus.grant), 'h1);
    bus.req = '0;
    @(negedge clock);
    chk("co_done", 32'(bus.done), 'h1);
    chk("co_no_tmo", 32'(bus.timeout_err), 0);
    chk("co_grant_low", 32'(bus.grant), 0);
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
